hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised successor to the fixed hazard/forwarding pair between the decode and execute stages.
//  Tracks in-flight register writers across STAGES post-decode slots (idx 0 = EX, 1 = MEM, 2 = WB, ...).
//  Per decoded instruction it produces:
//   - load-use / latency stall
//   - registered forward selects for both source operands, consumed by execute one cycle later.
//  Also supports a global mem_wait freeze and a branch flush.
// PARAMETERS
//  NUM_REGS     8  architectural registers; REG_W = $clog2(NUM_REGS)
//  STAGES       3  tracked slots after decode (>=2)
//  ALU_FWD_MIN  1  lowest slot index from which a non-load result can be forwarded
//  LOAD_FWD_MIN 2  lowest slot index from which a load result can be forwarded (>=ALU_FWD_MIN)
//  FWD_W = $clog2(STAGES+1)
// PORTS
//  clk        in   1      clock
//  rst        in   1      async active-high reset
//  id_valid   in   1      decode slot holds a real instruction
//  id_rs      in   REG_W  source A register
//  id_rs_used in   1      source A is read
//  id_rt      in   REG_W  source B register
//  id_rt_used in   1      source B is read
//  id_wr_en   in   1      instruction writes a register
//  id_wr_reg  in   REG_W  destination register
//  id_is_load in   1      destination is written from memory
//  flush      in   1      kill the decode-slot instruction (branch/jump taken in EX)
//  mem_wait   in   1      memory not ready; freeze whole pipeline
//  stall      out  1      hold PC and IF/ID; bubble into EX
//  fwd_a      out  FWD_W  EX operand A source: 0 = register file, k = slot k-1 result
//  fwd_b      out  FWD_W  same for operand B
//  busy       out  1      any valid writer in slots
//  err        out  1      illegal condition flagged
// BEHAVIOUR
//  Slot entry: {v, wr, reg, load}.
//  Reset clears every v; fwd_a = fwd_b = 0; err = 0.
//  Reset is asynchronous: it takes effect mid-stall or mid-freeze and discards all tracked writers.
//  Hazard check (combinational): for source S (used, id_valid), scan slots s = 0..STAGES-1, youngest (lowest s) first.
//   - First match on v & wr & reg == S decides.
//   - Producer reaches slot s+1 when the consumer enters EX.
//   - Need = load ? LOAD_FWD_MIN : ALU_FWD_MIN.
//   - s+1 >= STAGES -> retired: fwd = 0 (RF writes before reads).
//   - s+1 < Need -> hazard.
//   - Otherwise fwd = s+2 (selects slot s+1).
//  stall = mem_wait | (hazard_a | hazard_b) & id_valid & ~flush.
//  Each clk edge, when mem_wait = 0:
//   - slots shift: slot[k+1] <= slot[k]; oldest entry retires.
//   - slot[0] <= bubble (v = 0) if stall | flush | ~id_valid; otherwise the decode instruction.
//   - fwd_a / fwd_b <= computed selects if issued, otherwise 0.
//  mem_wait = 1: slots and fwd registers hold; stall = 1.
//  Latency: the stall decision is same-cycle; the forward select is visible the cycle after issue and
//   is held stable while execute is frozen.
//  Simultaneous events:
//   - flush overrides hazard: no stall, bubble issued.
//   - flush & mem_wait: freeze wins, flush must be re-presented; err pulses one cycle.
//   - A source matching several slots uses the youngest only.
//   - A source with used = 0 never stalls and forwards 0.
//  busy = OR of (v & wr) over all slots.
//  err (registered, sticky until reset):
//   - id_wr_reg >= NUM_REGS while id_valid & id_wr_en.
//   - flush & mem_wait, as above (one-cycle pulse).
// TESTING
//  1. Reset, no writers, id_valid = 1 -> stall = 0, fwd = 0, busy = 0.
//  2. ALU writes r3, next instr reads r3 as rs -> no stall; fwd_a = 2 (slot 1) on the following cycle.
//  3. Load r2, next instr reads r2 as rt -> stall 1 cycle, bubble; then issue with fwd_b = 3 (slot 2).
//  4. Writers r1 then r1 back-to-back, consumer reads r1 -> fwd selects the younger (slot 1), value 2.
//  5. mem_wait high 3 cycles mid-hazard -> slots/fwd frozen, stall = 1; after release, resume exactly.
//  6. flush during load-use hazard -> stall = 0, bubble issued; flush & mem_wait -> err = 1.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Decode-side hazard scoreboard: tracks in-flight writers after decode,
// raises load-use stalls and registers operand forward selects for execute.
module hazard_scoreboard #(
  parameter  int NUM_REGS     = 8,
  parameter  int STAGES       = 3,
  parameter  int ALU_FWD_MIN  = 1,
  parameter  int LOAD_FWD_MIN = 2,
  localparam int REG_W        = $clog2(NUM_REGS),
  localparam int FWD_W        = $clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic             id_rs_used,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rt_used,
  input  logic             id_wr_en,
  input  logic [REG_W-1:0] id_wr_reg,
  input  logic             id_is_load,
  input  logic             flush,
  input  logic             mem_wait,
  output logic             stall,
  output logic [FWD_W-1:0] fwd_a,
  output logic [FWD_W-1:0] fwd_b,
  output logic             busy,
  output logic             err
);

  typedef struct packed {
    logic             v;
    logic             wr;
    logic [REG_W-1:0] rg;
    logic             ld;
  } slot_t;

  slot_t            r_slot [STAGES];
  logic [FWD_W-1:0] r_fwd_a;
  logic [FWD_W-1:0] r_fwd_b;
  logic             r_err_sticky;
  logic             r_err_pulse;

  logic [1:0][REG_W-1:0] w_src;
  logic [1:0]            w_used;
  logic [1:0]            w_haz;
  logic [1:0][FWD_W-1:0] w_fwd;
  logic                  w_busy;
  logic                  w_stall;
  logic                  w_issue;
  logic                  w_bad_wr;
  slot_t                 w_new;

  assign w_src  = {id_rt, id_rs};
  assign w_used = {id_rt_used, id_rs_used};

  // Youngest matching slot decides; the producer is one slot older by the
  // time the consumer reaches execute.
  always_comb begin
    logic hit;
    w_haz = '0;
    w_fwd = '0;
    for (int o = 0; o < 2; o++) begin
      hit = 1'b0;
      for (int s = 0; s < STAGES; s++) begin
        if (!hit && w_used[o] && r_slot[s].v && r_slot[s].wr &&
            r_slot[s].rg == w_src[o]) begin
          hit = 1'b1;
          if (s + 1 >= STAGES) begin
            w_fwd[o] = '0;
          end else if (s + 1 < (r_slot[s].ld ? LOAD_FWD_MIN
                                             : ALU_FWD_MIN)) begin
            w_haz[o] = 1'b1;
          end else begin
            w_fwd[o] = FWD_W'(s + 2);
          end
        end
      end
    end
  end

  always_comb begin
    w_busy = 1'b0;
    for (int s = 0; s < STAGES; s++) begin
      w_busy = w_busy | (r_slot[s].v & r_slot[s].wr);
    end
  end

  assign w_stall  = mem_wait | ((|w_haz) & id_valid & ~flush);
  assign w_issue  = id_valid & ~w_stall & ~flush;
  assign w_bad_wr = id_valid & id_wr_en &
                    (int'(id_wr_reg) >= NUM_REGS);

  always_comb begin
    w_new    = '0;
    w_new.v  = 1'b1;
    w_new.wr = id_wr_en;
    w_new.rg = id_wr_reg;
    w_new.ld = id_is_load;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_slot[k] <= '0;
      end
      r_fwd_a      <= '0;
      r_fwd_b      <= '0;
      r_err_sticky <= 1'b0;
      r_err_pulse  <= 1'b0;
    end else begin
      r_err_pulse <= flush & mem_wait;
      if (w_bad_wr) begin
        r_err_sticky <= 1'b1;
      end
      if (!mem_wait) begin
        for (int k = STAGES - 1; k > 0; k--) begin
          r_slot[k] <= r_slot[k-1];
        end
        r_slot[0] <= w_issue ? w_new : '0;
        r_fwd_a   <= w_issue ? w_fwd[0] : '0;
        r_fwd_b   <= w_issue ? w_fwd[1] : '0;
      end
    end
  end

  assign stall = w_stall;
  assign fwd_a = r_fwd_a;
  assign fwd_b = r_fwd_b;
  assign busy  = w_busy;
  assign err   = r_err_sticky | r_err_pulse;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scenario bench for hazard_scoreboard: expected forward selects are queued
// as each decode cycle is driven and popped once the registers update.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [2:0] id_rs;
  logic       id_rs_used;
  logic [2:0] id_rt;
  logic       id_rt_used;
  logic       id_wr_en;
  logic [2:0] id_wr_reg;
  logic       id_is_load;
  logic       flush;
  logic       mem_wait;
  logic       stall;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       busy;
  logic       err;

  int         n_vec = 0;
  int         n_err = 0;
  logic [3:0] sb [$];
  logic [3:0] e;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rs_used (id_rs_used),
    .id_rt      (id_rt),
    .id_rt_used (id_rt_used),
    .id_wr_en   (id_wr_en),
    .id_wr_reg  (id_wr_reg),
    .id_is_load (id_is_load),
    .flush      (flush),
    .mem_wait   (mem_wait),
    .stall      (stall),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b),
    .busy       (busy),
    .err        (err)
  );

  task automatic drive(input logic v, input logic [2:0] rs,
                       input logic rsu, input logic [2:0] rt,
                       input logic rtu, input logic we,
                       input logic [2:0] wr, input logic ld,
                       input logic fl, input logic mw);
    id_valid   = v;
    id_rs      = rs;
    id_rs_used = rsu;
    id_rt      = rt;
    id_rt_used = rtu;
    id_wr_en   = we;
    id_wr_reg  = wr;
    id_is_load = ld;
    flush      = fl;
    mem_wait   = mw;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    sb.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 3, 1, 3, 1, 0, 0, 0, 0, 0);
    tick();
    tick();
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b exp 0", stall); end
    n_vec++; if (fwd_a !== 2'd0) begin n_err++; $display("FAIL reset_fwd_a got %0d exp 0", fwd_a); end
    n_vec++; if (fwd_b !== 2'd0) begin n_err++; $display("FAIL reset_fwd_b got %0d exp 0", fwd_b); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err got %b exp 0", err); end
    rst = 1'b0;
    drain();
  endtask

  task automatic test_alu_fwd();
    drive(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    sb.push_back(4'b0000);
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL alu_wr_stall got %b exp 0", stall); end
    tick();
    e = sb.pop_front();
    n_vec++; if ({fwd_a, fwd_b} !== e) begin n_err++; $display("FAIL alu_wr_fwd got %h exp %h", {fwd_a, fwd_b}, e); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL alu_busy got %b exp 1", busy); end
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    sb.push_back({2'd2, 2'd0});
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL alu_use_stall got %b exp 0", stall); end
    tick();
    e = sb.pop_front();
    n_vec++; if ({fwd_a, fwd_b} !== e) begin n_err++; $display("FAIL alu_use_fwd got %h exp %h", {fwd_a, fwd_b}, e); end
    drain();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL alu_drained_busy got %b exp 0", busy); end
  endtask

  task automatic test_load_use();
    drive(1, 0, 0, 0, 0, 1, 2, 1, 0, 0);
    sb.push_back(4'b0000);
    tick();
    e = sb.pop_front();
    n_vec++; if ({fwd_a, fwd_b} !== e) begin n_err++; $display("FAIL ld_issue_fwd got %h exp %h", {fwd_a, fwd_b}, e); end
    drive(1, 5, 1, 2, 1, 0, 0, 0, 0, 0);
    sb.push_back(4'b0000);
    #1;
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL ld_use_stall got %b exp 1", stall); end
    tick();
    e = sb.pop_front();
    n_vec++; if ({fwd_a, fwd_b} !== e) begin n_err++; $display("FAIL ld_bubble_fwd got %h exp %h", {fwd_a, fwd_b}, e); end
    sb.push_back({2'd0, 2'd3});
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL ld_retry_stall got %b exp 0", stall); end
    tick();
    e = sb.pop_front();
    n_vec++; if ({fwd_a, fwd_b} !== e) begin n_err++; $display("FAIL ld_retry_fwd got %h exp %h", {fwd_a, fwd_b}, e); end
    drain();
  endtask

  task automatic test_back_to_back();
    drive(1, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL b2b_wr_stall got %b exp 0", stall); end
    tick();
    drive(1, 1, 1, 1, 1, 0, 0, 0, 0, 0);
    sb.push_back({2'd2, 2'd2});
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL b2b_use_stall got %b exp 0", stall); end
    tick();
    e = sb.pop_front();
    n_vec++; if ({fwd_a, fwd_b} !== e) begin n_err++; $display("FAIL b2b_fwd got %h exp %h", {fwd_a, fwd_b}, e); end
    drain();
  endtask

  task automatic test_retire();
    drive(1, 0, 0, 0, 0, 1, 4, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 4, 1, 0, 0, 0, 0, 0, 0, 0);
    sb.push_back({2'd3, 2'd0});
    tick();
    e = sb.pop_front();
    n_vec++; if ({fwd_a, fwd_b} !== e) begin n_err++; $display("FAIL ret_slot2_fwd got %h exp %h", {fwd_a, fwd_b}, e); end
    drive(1, 0, 0, 4, 1, 0, 0, 0, 0, 0);
    sb.push_back(4'b0000);
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL ret_stall got %b exp 0", stall); end
    tick();
    e = sb.pop_front();
    n_vec++; if ({fwd_a, fwd_b} !== e) begin n_err++; $display("FAIL ret_rf_fwd got %h exp %h", {fwd_a, fwd_b}, e); end
    drain();
  endtask

  task automatic test_unused();
    drive(1, 0, 0, 0, 0, 1, 2, 1, 0, 0);
    tick();
    drive(1, 2, 0, 2, 0, 0, 0, 0, 0, 0);
    sb.push_back(4'b0000);
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL unused_stall got %b exp 0", stall); end
    tick();
    e = sb.pop_front();
    n_vec++; if ({fwd_a, fwd_b} !== e) begin n_err++; $display("FAIL unused_fwd got %h exp %h", {fwd_a, fwd_b}, e); end
    drain();
  endtask

  task automatic test_mem_wait();
    drive(1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
    tick();
    drive(1, 7, 1, 0, 0, 1, 6, 1, 0, 0);
    sb.push_back({2'd2, 2'd0});
    tick();
    e = sb.pop_front();
    n_vec++; if ({fwd_a, fwd_b} !== e) begin n_err++; $display("FAIL mw_pre_fwd got %h exp %h", {fwd_a, fwd_b}, e); end
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 6, 1, 0, 0, 0, 0, 1);
      sb.push_back({2'd2, 2'd0});
      #1;
      n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL mw_freeze_stall[%0d] got %b exp 1", i, stall); end
      tick();
      e = sb.pop_front();
      n_vec++; if ({fwd_a, fwd_b} !== e) begin n_err++; $display("FAIL mw_hold_fwd[%0d] got %h exp %h", i, {fwd_a, fwd_b}, e); end
    end
    drive(1, 0, 0, 6, 1, 0, 0, 0, 0, 0);
    sb.push_back(4'b0000);
    #1;
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL mw_resume_stall got %b exp 1", stall); end
    tick();
    e = sb.pop_front();
    n_vec++; if ({fwd_a, fwd_b} !== e) begin n_err++; $display("FAIL mw_bubble_fwd got %h exp %h", {fwd_a, fwd_b}, e); end
    sb.push_back({2'd0, 2'd3});
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL mw_issue_stall got %b exp 0", stall); end
    tick();
    e = sb.pop_front();
    n_vec++; if ({fwd_a, fwd_b} !== e) begin n_err++; $display("FAIL mw_issue_fwd got %h exp %h", {fwd_a, fwd_b}, e); end
    drain();
  endtask

  task automatic test_flush();
    drive(1, 0, 0, 0, 0, 1, 5, 1, 0, 0);
    tick();
    drive(1, 5, 1, 0, 0, 1, 4, 0, 1, 0);
    sb.push_back(4'b0000);
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL fl_stall got %b exp 0", stall); end
    tick();
    e = sb.pop_front();
    n_vec++; if ({fwd_a, fwd_b} !== e) begin n_err++; $display("FAIL fl_bubble_fwd got %h exp %h", {fwd_a, fwd_b}, e); end
    drive(1, 4, 1, 0, 0, 0, 0, 0, 0, 0);
    sb.push_back(4'b0000);
    tick();
    e = sb.pop_front();
    n_vec++; if ({fwd_a, fwd_b} !== e) begin n_err++; $display("FAIL fl_killed_fwd got %h exp %h", {fwd_a, fwd_b}, e); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL fl_err_pre got %b exp 0", err); end
    drive(1, 5, 1, 0, 0, 0, 0, 0, 1, 1);
    sb.push_back(4'b0000);
    #1;
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL flmw_stall got %b exp 1", stall); end
    tick();
    e = sb.pop_front();
    n_vec++; if ({fwd_a, fwd_b} !== e) begin n_err++; $display("FAIL flmw_fwd got %h exp %h", {fwd_a, fwd_b}, e); end
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL flmw_err got %b exp 1", err); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL flmw_err_pulse got %b exp 0", err); end
    drain();
  endtask

  task automatic test_async_reset();
    drive(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    tick();
    drive(1, 3, 1, 0, 0, 1, 2, 1, 0, 0);
    sb.push_back({2'd2, 2'd0});
    tick();
    e = sb.pop_front();
    n_vec++; if ({fwd_a, fwd_b} !== e) begin n_err++; $display("FAIL ar_pre_fwd got %h exp %h", {fwd_a, fwd_b}, e); end
    drive(1, 0, 0, 2, 1, 0, 0, 0, 0, 1);
    #1;
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL ar_freeze_stall got %b exp 1", stall); end
    #1 rst = 1'b1;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ar_busy got %b exp 0", busy); end
    n_vec++; if ({fwd_a, fwd_b} !== 4'b0000) begin n_err++; $display("FAIL ar_fwd got %h exp 0", {fwd_a, fwd_b}); end
    rst = 1'b0;
    drive(1, 0, 0, 2, 1, 0, 0, 0, 0, 0);
    sb.push_back(4'b0000);
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL ar_post_stall got %b exp 0", stall); end
    tick();
    e = sb.pop_front();
    n_vec++; if ({fwd_a, fwd_b} !== e) begin n_err++; $display("FAIL ar_post_fwd got %h exp %h", {fwd_a, fwd_b}, e); end
    drain();
  endtask

  initial begin
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_back_to_back();
    test_retire();
    test_unused();
    test_mem_wait();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
